// File: rtl/lc3_ctrl_pkg.sv
// Shared types and encodings for the LC3 control sequencer: FSM states, opcodes,
// memory-select codes and the opcode classes produced by lc3_op_classify.
package lc3_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_EXECUTE   = 4'd3,
      S_MEM_IND   = 4'd4,
      S_MEM_READ  = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_WRITEBACK = 4'd7,
      S_UPDATE_PC = 4'd8
   } state_e;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_RTI  = 4'b1000;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_RES  = 4'b1101;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;

   localparam logic [1:0] MEM_RD   = 2'b00;
   localparam logic [1:0] MEM_IND  = 2'b01;
   localparam logic [1:0] MEM_WR   = 2'b10;
   localparam logic [1:0] MEM_IDLE = 2'b11;

   typedef enum logic [2:0] {
      CLS_ALU       = 3'd0,
      CLS_LOAD      = 3'd1,
      CLS_LOAD_IND  = 3'd2,
      CLS_STORE     = 3'd3,
      CLS_STORE_IND = 3'd4,
      CLS_CTRL      = 3'd5,
      CLS_ILLEGAL   = 3'd6
   } op_class_e;

endpackage

// File: rtl/lc3_op_classify.sv
// Purely combinational opcode-to-class map; JSR, RTI, TRAP and the reserved
// opcode 1101 map to CLS_ILLEGAL.
module lc3_op_classify
   import lc3_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   output op_class_e  op_class
);

   always_comb begin
      op_class = CLS_ILLEGAL;
      case (opcode)
         OP_ADD, OP_AND, OP_NOT, OP_LEA: op_class = CLS_ALU;
         OP_LD, OP_LDR:                  op_class = CLS_LOAD;
         OP_LDI:                         op_class = CLS_LOAD_IND;
         OP_ST, OP_STR:                  op_class = CLS_STORE;
         OP_STI:                         op_class = CLS_STORE_IND;
         OP_BR, OP_JMP:                  op_class = CLS_CTRL;
         default:                        op_class = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/lc3_decode_sequencer.sv
// Multi-cycle LC3 control FSM: steps one instruction through fetch, decode,
// execute, optional memory access, writeback and PC update with Moore outputs.
module lc3_decode_sequencer
   import lc3_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      instr_dout,
   input  logic             complete_instr,
   input  logic             complete_data,
   input  logic [2:0]       psr,
   output logic             enable_fetch,
   output logic             enable_decode,
   output logic             enable_execute,
   output logic             enable_writeback,
   output logic             enable_updatePC,
   output logic             br_taken,
   output logic [1:0]       mem_state,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_q, state_d;
   logic [3:0]       opcode_q, opcode_d;
   logic [2:0]       nzp_q, nzp_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instr_count_q, instr_count_d;
   op_class_e        op_class;

   // Only opcode and condition bits matter to sequencing.
   logic unused_instr_bits;
   assign unused_instr_bits = ^instr_dout[8:0];

   lc3_op_classify u_classify (
      .opcode   (opcode_q),
      .op_class (op_class)
   );

   always_comb begin
      state_d       = state_q;
      opcode_d      = opcode_q;
      nzp_d         = nzp_q;
      illegal_d     = 1'b0;
      instr_count_d = instr_count_q;
      case (state_q)
         S_IDLE:    if (start) state_d = S_FETCH;
         S_FETCH:   if (complete_instr) state_d = S_DECODE;
         S_DECODE: begin
            opcode_d = instr_dout[15:12];
            nzp_d    = instr_dout[11:9];
            state_d  = S_EXECUTE;
         end
         S_EXECUTE: begin
            case (op_class)
               CLS_ALU:                     state_d = S_WRITEBACK;
               CLS_LOAD:                    state_d = S_MEM_READ;
               CLS_LOAD_IND, CLS_STORE_IND: state_d = S_MEM_IND;
               CLS_STORE:                   state_d = S_MEM_WRITE;
               CLS_CTRL:                    state_d = S_UPDATE_PC;
               default: begin
                  state_d   = S_UPDATE_PC;
                  illegal_d = 1'b1;
               end
            endcase
         end
         // The indirect pointer fetch is shared by LDI and STI; the class picks the follow-up access.
         S_MEM_IND:
            if (complete_data)
               state_d = (op_class == CLS_STORE_IND) ? S_MEM_WRITE : S_MEM_READ;
         S_MEM_READ:  if (complete_data) state_d = S_WRITEBACK;
         S_MEM_WRITE: if (complete_data) state_d = S_UPDATE_PC;
         S_WRITEBACK: state_d = S_UPDATE_PC;
         S_UPDATE_PC: begin
            state_d       = S_FETCH;
            instr_count_d = instr_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         opcode_q      <= 4'b0000;
         nzp_q         <= 3'b000;
         illegal_q     <= 1'b0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         opcode_q      <= opcode_d;
         nzp_q         <= nzp_d;
         illegal_q     <= illegal_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      enable_fetch     = (state_q == S_FETCH);
      enable_decode    = (state_q == S_DECODE);
      enable_execute   = (state_q == S_EXECUTE);
      enable_writeback = (state_q == S_WRITEBACK);
      enable_updatePC  = (state_q == S_UPDATE_PC);
      case (state_q)
         S_MEM_IND:   mem_state = MEM_IND;
         S_MEM_READ:  mem_state = MEM_RD;
         S_MEM_WRITE: mem_state = MEM_WR;
         default:     mem_state = MEM_IDLE;
      endcase
      br_taken = 1'b0;
      if (state_q == S_UPDATE_PC) begin
         if (opcode_q == OP_BR)
            br_taken = |(nzp_q & psr);
         else if (opcode_q == OP_JMP)
            br_taken = 1'b1;
      end
   end

   assign illegal_op  = illegal_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_lc3_decode_sequencer.sv
// Directed bench for lc3_decode_sequencer: walks each instruction class through
// its state sequence cycle by cycle and checks enables, mem_state and flags.
module tb_lc3_decode_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] instr_dout = 16'h0000;
   logic        complete_instr = 1'b0;
   logic        complete_data = 1'b0;
   logic [2:0]  psr = 3'b000;
   logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
   logic        br_taken;
   logic [1:0]  mem_state;
   logic        illegal_op;
   logic [15:0] instr_count;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_count = 16'd0;

   localparam logic [4:0] EN_0 = 5'b00000;
   localparam logic [4:0] EN_F = 5'b10000;
   localparam logic [4:0] EN_D = 5'b01000;
   localparam logic [4:0] EN_E = 5'b00100;
   localparam logic [4:0] EN_W = 5'b00010;
   localparam logic [4:0] EN_U = 5'b00001;

   wire [4:0] en = {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC};

   lc3_decode_sequencer #(.CNT_W(16)) dut (
      .clock            (clock),
      .reset            (reset),
      .start            (start),
      .instr_dout       (instr_dout),
      .complete_instr   (complete_instr),
      .complete_data    (complete_data),
      .psr              (psr),
      .enable_fetch     (enable_fetch),
      .enable_decode    (enable_decode),
      .enable_execute   (enable_execute),
      .enable_writeback (enable_writeback),
      .enable_updatePC  (enable_updatePC),
      .br_taken         (br_taken),
      .mem_state        (mem_state),
      .illegal_op       (illegal_op),
      .instr_count      (instr_count)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      #2 reset = 1'b0;
      tick;
      tick;
      checks++; if (en !== EN_0) begin errors++; $display("FAIL reset_en got=%b want=%b", en, EN_0); end
      checks++; if (mem_state !== 2'b11) begin errors++; $display("FAIL reset_mem got=%b want=11", mem_state); end
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL reset_br got=%b want=0", br_taken); end
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", illegal_op); end
      checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%h want=0000", instr_count); end
      $display("reset: en=%b mem=%b count=%0d", en, mem_state, instr_count);
   endtask

   task automatic test_add;
      logic [4:0] seq [5];
      seq = '{EN_F, EN_D, EN_E, EN_W, EN_U};
      reset = 1'b1;
      start = 1'b1;
      instr_dout = 16'h1021;
      complete_instr = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick;
         if (i == 1) start = 1'b0;
         if (i == 4) complete_instr = 1'b0;
         checks++; if (en !== seq[i]) begin errors++; $display("FAIL add_en[%0d] got=%b want=%b", i, en, seq[i]); end
         checks++; if (mem_state !== 2'b11) begin errors++; $display("FAIL add_mem[%0d] got=%b want=11", i, mem_state); end
         if (i == 4) begin
            checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL add_br got=%b want=0", br_taken); end
         end
      end
      exp_count = exp_count + 16'd1;
      tick;
      checks++; if (en !== EN_F) begin errors++; $display("FAIL add_refetch got=%b want=%b", en, EN_F); end
      checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL add_count got=%h want=%h", instr_count, exp_count); end
      tick;
      checks++; if (en !== EN_F) begin errors++; $display("FAIL add_fetch_hold got=%b want=%b", en, EN_F); end
      $display("ADD 1021 retired count=%0d", instr_count);
   endtask

   task automatic test_ldi;
      psr = 3'b001;
      instr_dout = 16'hA201;
      complete_instr = 1'b1;
      tick;
      complete_instr = 1'b0;
      checks++; if (en !== EN_D) begin errors++; $display("FAIL ldi_decode got=%b want=%b", en, EN_D); end
      tick;
      checks++; if (en !== EN_E) begin errors++; $display("FAIL ldi_exec got=%b want=%b", en, EN_E); end
      tick;
      for (int i = 0; i < 4; i++) begin
         complete_data = (i == 3);
         checks++; if (en !== EN_0) begin errors++; $display("FAIL ldi_ind_en[%0d] got=%b want=%b", i, en, EN_0); end
         checks++; if (mem_state !== 2'b01) begin errors++; $display("FAIL ldi_ind_mem[%0d] got=%b want=01", i, mem_state); end
         tick;
      end
      for (int i = 0; i < 4; i++) begin
         complete_data = (i == 3);
         checks++; if (en !== EN_0) begin errors++; $display("FAIL ldi_rd_en[%0d] got=%b want=%b", i, en, EN_0); end
         checks++; if (mem_state !== 2'b00) begin errors++; $display("FAIL ldi_rd_mem[%0d] got=%b want=00", i, mem_state); end
         tick;
      end
      complete_data = 1'b0;
      checks++; if (en !== EN_W) begin errors++; $display("FAIL ldi_wb got=%b want=%b", en, EN_W); end
      checks++; if (mem_state !== 2'b11) begin errors++; $display("FAIL ldi_wb_mem got=%b want=11", mem_state); end
      tick;
      checks++; if (en !== EN_U) begin errors++; $display("FAIL ldi_upc got=%b want=%b", en, EN_U); end
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL ldi_br got=%b want=0", br_taken); end
      exp_count = exp_count + 16'd1;
      tick;
      checks++; if (en !== EN_F) begin errors++; $display("FAIL ldi_refetch got=%b want=%b", en, EN_F); end
      checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL ldi_count got=%h want=%h", instr_count, exp_count); end
      $display("LDI A201 retired count=%0d", instr_count);
   endtask

   task automatic test_branch;
      logic [15:0] t_instr [5];
      logic [2:0]  t_psr   [5];
      logic        t_br    [5];
      t_instr = '{16'h0402, 16'h0402, 16'h0E05, 16'hC1C0, 16'h0003};
      t_psr   = '{3'b010,   3'b001,   3'b100,   3'b000,   3'b111};
      t_br    = '{1'b1,     1'b0,     1'b1,     1'b1,     1'b0};
      for (int k = 0; k < 5; k++) begin
         psr = t_psr[k];
         instr_dout = t_instr[k];
         complete_instr = 1'b1;
         tick;
         complete_instr = 1'b0;
         checks++; if (en !== EN_D) begin errors++; $display("FAIL br%0d_decode got=%b want=%b", k, en, EN_D); end
         tick;
         checks++; if (en !== EN_E) begin errors++; $display("FAIL br%0d_exec got=%b want=%b", k, en, EN_E); end
         tick;
         checks++; if (en !== EN_U) begin errors++; $display("FAIL br%0d_upc got=%b want=%b", k, en, EN_U); end
         checks++; if (mem_state !== 2'b11) begin errors++; $display("FAIL br%0d_mem got=%b want=11", k, mem_state); end
         checks++; if (br_taken !== t_br[k]) begin errors++; $display("FAIL br%0d_taken got=%b want=%b", k, br_taken, t_br[k]); end
         exp_count = exp_count + 16'd1;
         tick;
         checks++; if (en !== EN_F) begin errors++; $display("FAIL br%0d_refetch got=%b want=%b", k, en, EN_F); end
         checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL br%0d_count got=%h want=%h", k, instr_count, exp_count); end
         $display("CTRL %h psr=%b retired count=%0d", t_instr[k], t_psr[k], instr_count);
      end
   endtask

   task automatic test_illegal;
      psr = 3'b111;
      instr_dout = 16'hD000;
      complete_instr = 1'b1;
      complete_data = 1'b1;
      tick;
      complete_instr = 1'b0;
      checks++; if (en !== EN_D) begin errors++; $display("FAIL ill_decode got=%b want=%b", en, EN_D); end
      tick;
      checks++; if (en !== EN_E) begin errors++; $display("FAIL ill_exec got=%b want=%b", en, EN_E); end
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_early got=%b want=0", illegal_op); end
      tick;
      checks++; if (en !== EN_U) begin errors++; $display("FAIL ill_upc got=%b want=%b", en, EN_U); end
      checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_pulse got=%b want=1", illegal_op); end
      checks++; if (mem_state !== 2'b11) begin errors++; $display("FAIL ill_mem got=%b want=11", mem_state); end
      checks++; if (br_taken !== 1'b0) begin errors++; $display("FAIL ill_br got=%b want=0", br_taken); end
      exp_count = exp_count + 16'd1;
      tick;
      complete_data = 1'b0;
      checks++; if (en !== EN_F) begin errors++; $display("FAIL ill_refetch got=%b want=%b", en, EN_F); end
      checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_clear got=%b want=0", illegal_op); end
      checks++; if (instr_count !== exp_count) begin errors++; $display("FAIL ill_count got=%h want=%h", instr_count, exp_count); end
      $display("ILLEGAL D000 retired count=%0d", instr_count);
   endtask

   task automatic test_wrap;
      force dut.instr_count_q = 16'hFFFF;
      tick;
      release dut.instr_count_q;
      tick;
      checks++; if (instr_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got=%h want=ffff", instr_count); end
      psr = 3'b000;
      instr_dout = 16'h1021;
      complete_instr = 1'b1;
      tick;
      complete_instr = 1'b0;
      tick;
      tick;
      tick;
      checks++; if (en !== EN_U) begin errors++; $display("FAIL wrap_upc got=%b want=%b", en, EN_U); end
      tick;
      checks++; if (en !== EN_F) begin errors++; $display("FAIL wrap_refetch got=%b want=%b", en, EN_F); end
      checks++; if (instr_count !== 16'h0000) begin errors++; $display("FAIL wrap_count got=%h want=0000", instr_count); end
      $display("ADD 1021 retired at wrap count=%0d", instr_count);
   endtask

   task automatic test_reset_mid;
      instr_dout = 16'h3000;
      complete_instr = 1'b1;
      tick;
      complete_instr = 1'b0;
      tick;
      tick;
      checks++; if (mem_state !== 2'b10) begin errors++; $display("FAIL rst_st_mem got=%b want=10", mem_state); end
      tick;
      checks++; if (mem_state !== 2'b10) begin errors++; $display("FAIL rst_st_wait got=%b want=10", mem_state); end
      reset = 1'b0;
      start = 1'b0;
      #1;
      checks++; if (en !== EN_0) begin errors++; $display("FAIL rst_mid_en got=%b want=%b", en, EN_0); end
      checks++; if (mem_state !== 2'b11) begin errors++; $display("FAIL rst_mid_mem got=%b want=11", mem_state); end
      checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL rst_mid_count got=%h want=0000", instr_count); end
      tick;
      tick;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (en !== EN_0) begin errors++; $display("FAIL rst_idle_en[%0d] got=%b want=%b", i, en, EN_0); end
         checks++; if (mem_state !== 2'b11) begin errors++; $display("FAIL rst_idle_mem[%0d] got=%b want=11", i, mem_state); end
      end
      start = 1'b1;
      tick;
      checks++; if (en !== EN_F) begin errors++; $display("FAIL rst_restart got=%b want=%b", en, EN_F); end
      $display("ST 3000 aborted by reset, restart en=%b", en);
   endtask

   initial begin
      test_reset;
      test_add;
      test_ldi;
      test_branch;
      test_illegal;
      test_wrap;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
